// File: rtl/pipe_out_fifo.sv
// Purpose     : output-side pipeline FIFO decoupling a producer stage from a stallable consumer.
// Latency     : one cycle from push to head visible; no same-cycle bypass from datain.
// Backpressure: in_allow = !full || out_allow, so a full FIFO still accepts when it pops.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (drops all held items and any same-cycle push)
//   validin    upstream holds a valid item
//   datain     upstream payload, sampled only on push
//   in_allow   FIFO can accept this cycle (feeds upstream out_allow)
//   validout   head entry is valid
//   dataout    head payload (don't-care while validout=0)
//   out_allow  downstream accepts the head this cycle
//   count      occupancy 0..DEPTH, present only when PIPE_OUT_FIFO_COUNT_EN is defined
module pipe_out_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validin,
  input  logic [WIDTH-1:0] datain,
  output logic             in_allow,
  output logic             validout,
  output logic [WIDTH-1:0] dataout,
  input  logic             out_allow
`ifdef PIPE_OUT_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate occupancy register.
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] storage [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // out_allow -> in_allow is the only combinational path through the block.
  assign in_allow = !full || out_allow;
  assign validout = !empty;
  assign dataout  = storage[rd_ptr[AW-1:0]];

  assign push = validin && in_allow;
  assign pop  = validout && out_allow;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is intentionally not reset; a write during reset is suppressed so
  // the dropped push leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && push) storage[wr_ptr[AW-1:0]] <= datain;
  end

`ifdef PIPE_OUT_FIFO_COUNT_EN
  // Modular difference of the wrap-extended pointers is the occupancy.
  assign count = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_pipe_out_fifo.sv
module tb_pipe_out_fifo;
  localparam int WIDTH = 100;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             validin;
  logic [WIDTH-1:0] datain;
  logic             in_allow;
  logic             validout;
  logic [WIDTH-1:0] dataout;
  logic             out_allow;
`ifdef PIPE_OUT_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  pipe_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .validin(validin),
    .datain(datain),
    .in_allow(in_allow),
    .validout(validout),
    .dataout(dataout),
    .out_allow(out_allow)
`ifdef PIPE_OUT_FIFO_COUNT_EN
    ,
    .count(count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered queue of held items plus a log of what the DUT
  // actually delivered on each pop.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] dut_log[$];
  bit               started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      started <= 1'b1;
    end else if (started) begin
      bit do_push;
      bit do_pop;
      do_pop  = (q.size() > 0) && out_allow;
      do_push = validin && ((q.size() < DEPTH) || out_allow);
      if (validout && out_allow) dut_log.push_back(dataout);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(datain);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("validout", validout, q.size() != 0);
      chk("in_allow", in_allow, (q.size() < DEPTH) || out_allow);
      if (q.size() != 0) chk("dataout", dataout, q[0]);
`ifdef PIPE_OUT_FIFO_COUNT_EN
      chk("count", count, q.size());
`endif
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic oa);
    validin   = v;
    datain    = d;
    out_allow = oa;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  // Drain with a bounded cycle budget; expiry counts as a failure.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (validout === 1'b1 && n < 40) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    chk({name, "_drain_done"}, validout, 1'b0);
  endtask

  task automatic chk_log(input string name, input int base, input int len, input int stride);
    chk({name, "_len"}, dut_log.size(), len);
    for (int i = 0; i < len && i < dut_log.size(); i++)
      chk($sformatf("%s_item%0d", name, i), dut_log[i], base + i * stride);
  endtask

  initial begin
    rst = 1'b0; validin = 1'b0; datain = '0; out_allow = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    chk("rst_validout", validout, 1'b0);
    chk("rst_in_allow", in_allow, 1'b1);
`ifdef PIPE_OUT_FIFO_COUNT_EN
    chk("rst_count", count, 0);
`endif

    // Single push becomes visible one edge later
    step(1'b1, 'hA5, 1'b0);
    chk("one_validout", validout, 1'b1);
    chk("one_dataout", dataout, 'hA5);
`ifdef PIPE_OUT_FIFO_COUNT_EN
    chk("one_count", count, 1);
`endif

    // Fill to full, fifth item held upstream
    do_reset();
    dut_log.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0);
    chk("full_in_allow", in_allow, 1'b0);
    chk("full_model_size", q.size(), 4);
`ifdef PIPE_OUT_FIFO_COUNT_EN
    chk("full_count", count, 4);
`endif
    step(1'b1, 5, 1'b0);
    chk("held_in_allow", in_allow, 1'b0);
    chk("held_head", dataout, 1);

    // Full FIFO accepts while popping
    validin = 1'b1; datain = 5; out_allow = 1'b1;
    #1;
    chk("fullpop_in_allow", in_allow, 1'b1);
    @(posedge clk); #1;
    chk("fullpop_head", dataout, 2);
    chk("fullpop_validout", validout, 1'b1);
`ifdef PIPE_OUT_FIFO_COUNT_EN
    chk("fullpop_count", count, 4);
`endif
    drain("fullpop");
    chk_log("fullpop_order", 1, 5, 1);

    // Streaming: push and pop every cycle, occupancy stays 0/1
    do_reset();
    dut_log.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 100 + i, 1'b1);
      chk($sformatf("stream_head%0d", i), dataout, 100 + i);
      chk($sformatf("stream_size%0d", i), q.size(), 1);
    end
    step(1'b0, '0, 1'b1);
    chk("stream_empty", validout, 1'b0);
    chk_log("stream_order", 100, 10, 1);

    // Reset mid-operation drops held items and the concurrent push
    dut_log.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 'h30 + i, 1'b0);
    chk("prerst_validout", validout, 1'b1);
    rst = 1'b1;
    step(1'b1, 'h77, 1'b1);
    rst = 1'b0;
    chk("midrst_validout", validout, 1'b0);
    chk("midrst_in_allow", in_allow, 1'b1);
`ifdef PIPE_OUT_FIFO_COUNT_EN
    chk("midrst_count", count, 0);
`endif
    step(1'b0, '0, 1'b1);
    chk("midrst_absent", validout, 1'b0);
    chk("midrst_log", dut_log.size(), 0);

    // Pointer wrap: 2*DEPTH+3 items with intermittent consumer stalls
    dut_log.delete();
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      logic oa;
      oa = (i % 3) != 0;
      validin = 1'b1; datain = 200 + i; out_allow = oa;
      begin
        int n;
        n = 0;
        #1;
        while (in_allow !== 1'b1 && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("wrap_accept%0d", i), in_allow, 1'b1);
      end
      @(posedge clk); #1;
    end
    drain("wrap");
    chk_log("wrap_order", 200, 2 * DEPTH + 3, 1);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_out_fifo.md
PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

Interface
REQ-001 Parameter: WIDTH, default 100, payload width in bits.
REQ-002 Parameter: DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 validin  input  1  upstream stage holds a valid item.
REQ-006 datain  input  WIDTH  upstream payload, sampled only on accept.
REQ-007 in_allow  output  1  FIFO can accept this cycle; drives upstream stage's out_allow.
REQ-008 validout  output  1  FIFO head holds a valid item.
REQ-009 dataout  output  WIDTH  head payload.
REQ-010 out_allow  input  1  downstream consumer accepts head this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  occupancy; present only per REQ-030.

Function
REQ-012 Push shall occur on a rising edge when validin && in_allow; pop shall occur when validout && out_allow.
REQ-013 in_allow shall equal !full || out_allow, so a full FIFO accepts in the same cycle it pops.
REQ-014 validout shall equal !empty; dataout shall equal storage[rd_ptr], combinational from registered state.
REQ-015 Latency: an item pushed at edge N shall be visible on validout/dataout after edge N when the FIFO was empty; no same-cycle bypass.
REQ-016 Order: strict FIFO; no item lost, duplicated, or reordered.
REQ-017 Pointers: wr_ptr and rd_ptr each $clog2(DEPTH)+1 bits; wrap modulo 2*DEPTH; index uses low bits.
REQ-018 full when pointers differ only in MSB; empty when pointers are equal.
REQ-019 Push only: wr_ptr +1, occupancy +1. Pop only: rd_ptr +1, occupancy -1.
REQ-020 Simultaneous push and pop: both pointers advance; occupancy unchanged; valid when empty only if validout=1 (i.e., not when empty, per REQ-015).
REQ-021 Push while full without pop shall not occur (in_allow=0); storage and wr_ptr unchanged.
REQ-022 Pop while empty shall not occur (validout=0); rd_ptr unchanged.
REQ-023 datain and storage contents shall be ignored when no push occurs; dataout is don't-care while validout=0.
REQ-024 No combinational path from validin or datain to any output; the only comb path is out_allow -> in_allow.

Reset
REQ-025 With rst=1 at a rising edge: wr_ptr=0, rd_ptr=0, validout=0, count=0, in_allow=1 after that edge.
REQ-026 Storage array shall not be reset; dataout undefined until first push.
REQ-027 Reset mid-operation shall discard all held items; a push requested in the reset cycle shall be dropped.
REQ-028 rst shall take priority over simultaneous push and pop.

Configuration
REQ-029 Macro PIPE_OUT_FIFO_COUNT_EN shall control the occupancy output.
REQ-030 Defined: port count exists, equals wr_ptr - rd_ptr (mod 2*DEPTH), range 0..DEPTH, updated with the pointers. Undefined: port count absent; all other behaviour identical.

Verification
REQ-031 Reset, then push A5 with out_allow=0 -> edge after: validout=1, dataout=A5, count=1.
REQ-032 out_allow=0, push 4 items 1,2,3,4 -> count=4, in_allow=0; 5th item held upstream, not written.
REQ-033 Full, validin=1 data 5, out_allow=1 -> in_allow=1; next edge head=2, count=4, eventual drain order 2,3,4,5.
REQ-034 Continuous push/pop for 10 items starting empty -> output sequence matches input, 1-cycle latency, count toggles 0/1 only.
REQ-035 Fill 3 items, assert rst one cycle with validin=1 -> validout=0, count=0, in_allow=1; pushed item absent afterwards.
REQ-036 Push/pop 2*DEPTH+3 items -> pointer wrap causes no false full/empty; all data correct in order.
